vga_fb_reader: RTL

Frame-buffer read scheduler feeding the pixel FIFO that drives `vga_ctrl`. Each frame it walks the visible area line by line and issues burst reads on a memory read port. It issues a burst only when the FIFO has room for the whole burst and writes the returned pixels into the FIFO. It resynchronises to the video timing on every frame-start pulse, so the FIFO never carries pixels across frames.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_fb_reader_if.sv | 26 ++
 rtl/vga_fb_addr_gen.sv | 55 +++++
 rtl/vga_fb_reader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared video types plus the frame-buffer reader's state encoding and default sizing.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vga_data_t;

  localparam vga_data_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

  localparam int FbBurstLen  = 16;
  localparam int FbFifoDepth = 512;

  typedef enum logic [2:0] {
    FB_IDLE,
    FB_FLUSH,
    FB_WAIT_SPACE,
    FB_REQ,
    FB_RECV,
    FB_DRAIN,
    FB_DONE
  } fb_state_t;

endpackage

// File: rtl/vga_fb_reader_if.sv
// Burst read port between the frame-buffer reader (master) and the memory (slave).
interface vga_fb_reader_if
  import vga_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 5
)();

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len;
   logic              gnt;
   logic              rvalid;
   vga_data_t         rdata;

   modport master (
      output req, addr, len,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, len,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// Walks the visible area: x/y/line_addr counters producing the next burst address and length.
module vga_fb_addr_gen #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int LINE_STRIDE = 640,
   parameter int FB_BASE     = 0,
   parameter int ADDR_W      = 24,
   parameter int BURST_LEN   = 16,
   localparam int LEN_W      = $clog2(BURST_LEN + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic              advance,
   input  logic [LEN_W-1:0]  adv_len,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  len,
   output logic              frame_done
);

   localparam int XW = $clog2(H_RES + 1);
   localparam int YW = $clog2(V_RES + 1);

   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [ADDR_W-1:0] line_addr_q;
   logic [XW-1:0]     remain;
   logic [XW-1:0]     x_sum;

   // Bursts are clipped to the end of the line so one never spans two lines.
   assign remain     = XW'(H_RES) - x_q;
   assign len        = (int'(remain) >= BURST_LEN) ? LEN_W'(BURST_LEN) : LEN_W'(remain);
   assign addr       = line_addr_q + ADDR_W'(x_q);
   assign frame_done = (y_q == YW'(V_RES));
   assign x_sum      = x_q + XW'(adv_len);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i || load) begin
         x_q         <= '0;
         y_q         <= '0;
         line_addr_q <= ADDR_W'(FB_BASE);
      end else if (advance) begin
         if (x_sum == XW'(H_RES)) begin
            x_q         <= '0;
            y_q         <= y_q + YW'(1);
            line_addr_q <= line_addr_q + ADDR_W'(LINE_STRIDE);
         end else begin
            x_q <= x_sum;
         end
      end
   end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer read scheduler: issues line-bounded bursts when the pixel FIFO has room
// and forwards returned beats into the FIFO, resynchronising on every frame start.
module vga_fb_reader
  import vga_pkg::*;
#(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int LINE_STRIDE = 640,
   parameter int FB_BASE     = 0,
   parameter int ADDR_W      = 24,
   parameter int BURST_LEN   = FbBurstLen,
   parameter int FIFO_DEPTH  = FbFifoDepth,
   localparam int LEN_W      = $clog2(BURST_LEN + 1),
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               frame_start_i,
   input  logic [LVL_W-1:0]   fifo_level_i,
   vga_fb_reader_if.master    mem,
   output logic               fifo_flush_o,
   output logic               fifo_wr_en_o,
   output vga_data_t          fifo_data_o,
   output logic               busy_o,
   output logic               frame_late_o
);

   fb_state_t         state_q, state_d;
   logic [LEN_W-1:0]  beat_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic              req_q, flush_q, wr_q, busy_q, late_q;
   vga_data_t         data_q;

   logic              late_d, wr_d, latch_req, grant_take, beat_take, last_beat;
   logic              ag_load, ag_adv, ag_frame_done, has_space;
   logic [ADDR_W-1:0] ag_addr;
   logic [LEN_W-1:0]  ag_len;

   vga_fb_addr_gen #(
      .H_RES       (H_RES),
      .V_RES       (V_RES),
      .LINE_STRIDE (LINE_STRIDE),
      .FB_BASE     (FB_BASE),
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load       (ag_load),
      .advance    (ag_adv),
      .adv_len    (len_q),
      .addr       (ag_addr),
      .len        (ag_len),
      .frame_done (ag_frame_done)
   );

   // The extra slot reserves room for the registered write still in flight.
   assign has_space = (32'(fifo_level_i) + 32'(BURST_LEN) + 32'd1) <= 32'(FIFO_DEPTH);
   assign last_beat = mem.rvalid && (beat_q == LEN_W'(1));

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      late_d     = 1'b0;
      wr_d       = 1'b0;
      latch_req  = 1'b0;
      grant_take = 1'b0;
      beat_take  = 1'b0;
      ag_load    = 1'b0;
      ag_adv     = 1'b0;

      unique case (state_q)
         FB_IDLE, FB_DONE: begin
            if (frame_start_i && enable_i) state_d = FB_FLUSH;
         end

         FB_FLUSH: begin
            ag_load = 1'b1;
            state_d = FB_WAIT_SPACE;
         end

         FB_WAIT_SPACE: begin
            if (ag_frame_done) begin
               // A frame start here is on time: the whole frame is already fetched.
               state_d = (frame_start_i && enable_i) ? FB_FLUSH : FB_DONE;
            end else if (frame_start_i) begin
               late_d  = 1'b1;
               state_d = FB_FLUSH;
            end else if (!enable_i) begin
               state_d = FB_IDLE;
            end else if (has_space) begin
               latch_req = 1'b1;
               state_d   = FB_REQ;
            end
         end

         FB_REQ: begin
            late_d = frame_start_i;
            if (mem.gnt) begin
               grant_take = 1'b1;
               state_d    = frame_start_i ? FB_DRAIN : FB_RECV;
            end else if (frame_start_i) begin
               state_d = FB_FLUSH;
            end
         end

         FB_RECV: begin
            beat_take = mem.rvalid;
            if (frame_start_i) begin
               late_d  = 1'b1;
               state_d = last_beat ? FB_FLUSH : FB_DRAIN;
            end else begin
               wr_d = mem.rvalid;
               if (last_beat) begin
                  ag_adv  = 1'b1;
                  state_d = FB_WAIT_SPACE;
               end
            end
         end

         FB_DRAIN: begin
            // A granted burst cannot be cancelled, so its beats are swallowed here.
            beat_take = mem.rvalid;
            if (last_beat) state_d = FB_FLUSH;
         end

         default: state_d = FB_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with state_q.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FB_IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         flush_q <= 1'b0;
         wr_q    <= 1'b0;
         data_q  <= BLACK;
         busy_q  <= 1'b0;
         late_q  <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= (state_d == FB_REQ);
         flush_q <= (state_d == FB_FLUSH);
         busy_q  <= !((state_d == FB_IDLE) || (state_d == FB_DONE));
         late_q  <= late_d;
         wr_q    <= wr_d;
         if (wr_d) data_q <= mem.rdata;
         if (latch_req) begin
            addr_q <= ag_addr;
            len_q  <= ag_len;
         end
         if (grant_take)     beat_q <= len_q;
         else if (beat_take) beat_q <= beat_q - LEN_W'(1);
      end
   end

   assign mem.req      = req_q;
   assign mem.addr     = addr_q;
   assign mem.len      = len_q;
   assign fifo_flush_o = flush_q;
   assign fifo_wr_en_o = wr_q;
   assign fifo_data_o  = data_q;
   assign busy_o       = busy_q;
   assign frame_late_o = late_q;

endmodule
